// File: rtl/sequential_elementwise_division.sv
// Sequential element-wise divider: divides L unsigned 2N-bit dividends by L
// unsigned N-bit divisors, one element at a time, using a restoring divider
// that produces one quotient bit per clock.
// Optional feature macro: SEQ_DIV_SKIP_ZERO_EN -- when defined, an element
// whose divisor is zero is resolved in its LOAD cycle instead of running the
// full division sequence.
module sequential_elementwise_division #(
    parameter int N = 8,
    parameter int L = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend  [0:L-1],
    input  logic [N-1:0]     divisor   [0:L-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   quotient  [0:L-1],
    output logic [N-1:0]     remainder [0:L-1],
    output logic [L-1:0]     div_zero,
    output logic             busy
);

    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t          state_reg;
    logic [IW-1:0]   idx_reg;
    logic [CW-1:0]   count_reg;
    logic [N-1:0]    rem_reg;
    logic [2*N-1:0]  shift_reg;
    logic [2*N-1:0]  dvd_reg [0:L-1];
    logic [N-1:0]    dvs_reg [0:L-1];

    logic [N-1:0]    cur_dvs;
    logic            cur_zero;
    logic [N:0]      trial;
    logic            qbit;
    logic [N-1:0]    rem_next;
    logic [2*N-1:0]  quo_next;

    assign cur_dvs  = dvs_reg[idx_reg];
    assign cur_zero = (cur_dvs == '0);

    // One restoring-division step. The shifted partial remainder needs N+1
    // bits; after a subtraction the result is below the divisor, so the
    // stored remainder fits in N bits and modular N-bit subtraction is exact.
    // The shift register holds the remaining dividend bits on the left and
    // collects quotient bits on the right.
    always_comb begin
        trial    = {rem_reg, shift_reg[2*N-1]};
        qbit     = (trial >= {1'b0, cur_dvs});
        rem_next = qbit ? (trial[N-1:0] - cur_dvs) : trial[N-1:0];
        quo_next = {shift_reg[2*N-2:0], qbit};
    end

    // Control FSM, operand capture, division datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx_reg   <= '0;
            count_reg <= '0;
            rem_reg   <= '0;
            shift_reg <= '0;
            div_zero  <= '0;
            for (int i = 0; i < L; i++) begin
                dvd_reg[i]   <= '0;
                dvs_reg[i]   <= '0;
                quotient[i]  <= '0;
                remainder[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < L; i++) begin
                            dvd_reg[i] <= dividend[i];
                            dvs_reg[i] <= divisor[i];
                        end
                        idx_reg   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    rem_reg   <= '0;
                    shift_reg <= dvd_reg[idx_reg];
                    count_reg <= '0;
                    state_reg <= DIV;
`ifdef SEQ_DIV_SKIP_ZERO_EN
                    // Zero divisor: the answer is known, skip the bit loop.
                    if (cur_zero) begin
                        quotient[idx_reg]  <= '1;
                        remainder[idx_reg] <= dvd_reg[idx_reg][N-1:0];
                        div_zero[idx_reg]  <= 1'b1;
                        if (idx_reg == IW'(L - 1)) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            state_reg <= LOAD;
                        end
                    end
`endif
                end
                DIV: begin
                    rem_reg   <= rem_next;
                    shift_reg <= quo_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(2 * N - 1)) begin
                        // Zero divisor results are forced so they do not
                        // depend on the bit loop's behaviour for that case.
                        quotient[idx_reg]  <= cur_zero ? '1 : quo_next;
                        remainder[idx_reg] <= cur_zero ? dvd_reg[idx_reg][N-1:0] : rem_next;
                        div_zero[idx_reg]  <= cur_zero;
                        if (idx_reg == IW'(L - 1)) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            state_reg <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_elementwise_division.sv
// Self-checking bench for sequential_elementwise_division: a transaction-level
// model predicts handshake signals and result arrays every cycle, and directed
// operations pin the model with hand-computed values.
module tb_sequential_elementwise_division;

    localparam int N   = 8;
    localparam int L   = 8;
    localparam int PER = 2 * N + 1;
`ifdef SEQ_DIV_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid, busy;
    logic [2*N-1:0]  dvd_in [0:L-1];
    logic [N-1:0]    dvs_in [0:L-1];
    logic [2*N-1:0]  quotient [0:L-1];
    logic [N-1:0]    remainder [0:L-1];
    logic [L-1:0]    div_zero;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int op_no = 0;

    sequential_elementwise_division #(.N(N), .L(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dvd_in),
        .divisor   (dvs_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
    mphase_t         m_phase;
    int              m_elapsed;
    int              m_lat;
    logic [2*N-1:0]  exp_q [0:L-1];
    logic [N-1:0]    exp_r [0:L-1];
    logic [L-1:0]    exp_z;

    function automatic int op_latency();
        int t = 0;
        for (int i = 0; i < L; i++)
            t += (SKIP && dvs_in[i] == 0) ? 1 : PER;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= M_IDLE;
            m_elapsed <= 0;
            m_lat     <= 0;
            exp_z     <= '0;
            for (int i = 0; i < L; i++) begin
                exp_q[i] <= '0;
                exp_r[i] <= '0;
            end
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    m_phase   <= M_RUN;
                    m_elapsed <= 0;
                    m_lat     <= op_latency();
                    for (int i = 0; i < L; i++) begin
                        exp_q[i] <= (dvs_in[i] == 0) ? 16'hFFFF : 16'(dvd_in[i] / dvs_in[i]);
                        exp_r[i] <= (dvs_in[i] == 0) ? dvd_in[i][N-1:0] : 8'(dvd_in[i] % dvs_in[i]);
                        exp_z[i] <= (dvs_in[i] == 0);
                    end
                end
                M_RUN: begin
                    m_elapsed <= m_elapsed + 1;
                    if (m_elapsed + 1 == m_lat) m_phase <= M_DONE;
                end
                M_DONE: if (out_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_phase == M_IDLE);
            chk("out_valid", out_valid, m_phase == M_DONE);
            chk("busy", busy, m_phase == M_RUN);
            if (m_phase != M_RUN) begin
                for (int i = 0; i < L; i++) begin
                    chk($sformatf("quotient[%0d]", i), quotient[i], exp_q[i]);
                    chk($sformatf("remainder[%0d]", i), remainder[i], exp_r[i]);
                end
                chk("div_zero", div_zero, exp_z);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input int a, input int b);
        for (int i = 0; i < L; i++) begin
            dvd_in[i] = 16'(a);
            dvs_in[i] = 8'(b);
        end
    endtask

    task automatic start_op();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        op_no++;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout actual=no out_valid required=out_valid within 600 cycles");
        end
        $display("op %0d: results after %0d cycles", op_no, lat);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    int lat;

    initial begin
        set_all(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q0", quotient[0], 0);
        chk("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_in_ready", in_ready, 1);

        // all elements 1000/7
        set_all(1000, 7);
        start_op();
        wait_done(lat);
        chk("lat_1000_7", lat, 136);
        for (int i = 0; i < L; i++) begin
            chk("q_1000_7", quotient[i], 142);
            chk("r_1000_7", remainder[i], 6);
        end
        chk("z_1000_7", div_zero, 8'h00);
        consume();

        // boundary values
        dvd_in[0] = 16'd65535; dvs_in[0] = 8'd1;
        dvd_in[1] = 16'd65535; dvs_in[1] = 8'd255;
        dvd_in[2] = 16'd0;     dvs_in[2] = 8'd9;
        dvd_in[3] = 16'd12345; dvs_in[3] = 8'd100;
        dvd_in[4] = 16'd5;     dvs_in[4] = 8'd200;
        dvd_in[5] = 16'd65534; dvs_in[5] = 8'd254;
        dvd_in[6] = 16'd40000; dvs_in[6] = 8'd199;
        dvd_in[7] = 16'd4660;  dvs_in[7] = 8'd17;
        start_op();
        wait_done(lat);
        chk("lat_bound", lat, 136);
        chk("q0_bound", quotient[0], 65535);
        chk("q1_bound", quotient[1], 257);
        chk("q2_bound", quotient[2], 0);
        chk("r0_bound", remainder[0], 0);
        chk("r1_bound", remainder[1], 0);
        chk("r2_bound", remainder[2], 0);
        chk("q5_bound", quotient[5], 258);
        chk("r6_bound", remainder[6], 1);
        consume();

        // zero divisor in element 3, then hold results in DONE
        set_all(1000, 7);
        dvd_in[3] = 16'h12AB; dvs_in[3] = 8'd0;
        start_op();
        wait_done(lat);
`ifdef SEQ_DIV_SKIP_ZERO_EN
        chk("lat_zero", lat, 120);
`else
        chk("lat_zero", lat, 136);
`endif
        chk("q3_zero", quotient[3], 16'hFFFF);
        chk("r3_zero", remainder[3], 8'hAB);
        chk("z_zero", div_zero, 8'h08);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            dvs_in[0] = 8'(k + 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_q3", quotient[3], 16'hFFFF);
            chk("hold_q0", quotient[0], 142);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();

        // reset in the middle of a division
        set_all(1000, 7);
        start_op();
        repeat (51) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_div_zero", div_zero, 0);
        for (int i = 0; i < L; i++) begin
            chk("midrst_q", quotient[i], 0);
            chk("midrst_r", remainder[i], 0);
        end
        $display("op %0d: aborted by reset", op_no);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        set_all(100, 10);
        start_op();
        wait_done(lat);
        chk("lat_100_10", lat, 136);
        for (int i = 0; i < L; i++) begin
            chk("q_100_10", quotient[i], 10);
            chk("r_100_10", remainder[i], 0);
        end
        consume();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequential_elementwise_division.md
SEQUENTIAL_ELEMENTWISE_DIVISION -- requirements
Module: sequential_elementwise_division

Interface
REQ-001 SHALL have parameter N, default 8, meaning divisor/remainder width in bits; dividend/quotient width is 2*N.
REQ-002 SHALL have parameter L, default 8, meaning elements per array.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand arrays present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port dividend  input  [2*N-1:0] x [0:L-1]  dividend array, unsigned.
REQ-008 SHALL have port divisor  input  [N-1:0] x [0:L-1]  divisor array, unsigned.
REQ-009 SHALL have port out_valid  output  1  result arrays valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts results.
REQ-011 SHALL have port quotient  output  [2*N-1:0] x [0:L-1]  per-element quotient.
REQ-012 SHALL have port remainder  output  [N-1:0] x [0:L-1]  per-element remainder.
REQ-013 SHALL have port div_zero  output  [L-1:0]  bit i set when divisor[i]==0.
REQ-014 SHALL have port busy  output  1  high in LOAD or DIV.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> DIV -> (LOAD | DONE) -> IDLE.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept on rising edge with in_valid&&in_ready, capturing all dividend/divisor elements into internal registers, element index=0, state->LOAD.
REQ-017 SHALL ignore dividend/divisor/in_valid changes outside the accept edge.
REQ-018 LOAD (1 cycle): running remainder (N+1 bits) <=0, shift register <=dividend[idx], iteration count <=0, state->DIV.
REQ-019 DIV (2*N cycles): restoring division, one quotient bit per cycle, MSB first: shift remainder left taking next dividend bit, subtract divisor if result >= divisor, set quotient bit accordingly.
REQ-020 On last DIV cycle SHALL write quotient[idx], remainder[idx], div_zero[idx]; if idx==L-1 ->DONE else idx+1, ->LOAD.
REQ-021 Divisor 0 SHALL yield quotient all ones, remainder = dividend[idx][N-1:0], div_zero[idx]=1.
REQ-022 Per element cost SHALL be 2*N+1 cycles; out_valid SHALL rise exactly L*(2*N+1) edges after accept (136 at defaults, macro absent).
REQ-023 DONE: out_valid=1, quotient/remainder/div_zero stable while out_ready=0; edge with out_ready=1 ->IDLE, out_valid=0 next cycle.
REQ-024 Output arrays SHALL retain last results in IDLE until overwritten element by element during next operation.
REQ-025 in_ready and out_valid SHALL never be high simultaneously; no new accept before results consumed.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, busy=0, quotient/remainder/div_zero/idx/count/internal operands=0.
REQ-027 Reset mid-LOAD/DIV/DONE SHALL discard operation; no out_valid until a new accept completes.

Configuration
REQ-028 Macro SEQ_DIV_SKIP_ZERO_EN defined: LOAD with divisor[idx]==0 SHALL write REQ-021 results directly and advance (1 cycle, skip DIV).
REQ-029 Macro absent: zero divisors SHALL traverse full 2*N DIV cycles; results identical to REQ-021 either way.

Verification
REQ-030 N=8,L=8, all elements 1000/7 -> quotient 142, remainder 6, div_zero 0x00, out_valid at 136 edges after accept.
REQ-031 Element 0 65535/1, element 1 65535/255, element 2 0/9 -> quotients 65535, 257, 0; remainders 0, 0, 0.
REQ-032 divisor[3]=0, dividend[3]=0x12AB -> quotient[3]=0xFFFF, remainder[3]=0xAB, div_zero=0x08; latency 136 without macro, 120 with SEQ_DIV_SKIP_ZERO_EN.
REQ-033 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst_n asserted at cycle 50 of DIV -> all outputs 0 immediately; after release, new operands 100/10 all elements -> quotient 10, remainder 0.
